// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end: bubble encoding, default
// reset PC and the fetch FSM state encoding.
package riscv_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_PENDING  = 2'd1,
    ST_BUFFERED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load enable plus a synchronous bubble load that
// wins over a normal load. Reset leaves a bubble in the register.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP   = WIDTH'(NOP_INST)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             bubble,
  input  logic [WIDTH-1:0] inst_in,
  input  logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             valid
);

  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

  // Capture a bubble or a real instruction; otherwise hold for stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst  <= NOP;
      pc    <= '0;
      valid <= 1'b0;
    end else if (bubble) begin
      inst  <= NOP;
      pc    <= '0;
      valid <= 1'b0;
    end else if (load) begin
      inst  <= inst_in;
      pc    <= pc_in;
      valid <= 1'b1;
    end
  end

  assign pc_plus4 = pc + FOUR;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with a one-cycle-latency synchronous memory, a one-entry
// response buffer so a stall never drops the response already in flight,
// and flush-driven redirect that costs exactly one bubble.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
  parameter logic [WIDTH-1:0] NOP      = WIDTH'(NOP_INST)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] imem_addr,
  output logic             imem_en,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] pc_id,
  output logic [WIDTH-1:0] pc_plus4_id,
  output logic             valid_id
);

  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

  fetch_state_t     state, state_nxt;
  logic [WIDTH-1:0] pc_f, rsp_pc, buf_inst, buf_pc;
  logic [WIDTH-1:0] target, ifid_inst_in, ifid_pc_in;
  logic             ifid_load, ifid_bubble, buf_load, issue;

  assign target    = {branch_target[WIDTH-1:2], 2'b00};
  assign imem_addr = flush ? target : pc_f;
  assign imem_en   = rst & (flush | !stall);

  // State register; reset returns to EMPTY so any in-flight response is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_EMPTY;
    else      state <= state_nxt;
  end

  // Next state and per-cycle control: flush beats stall beats advance.
  always_comb begin
    state_nxt    = state;
    ifid_load    = 1'b0;
    ifid_bubble  = 1'b0;
    buf_load     = 1'b0;
    issue        = 1'b0;
    ifid_inst_in = imem_rdata;
    ifid_pc_in   = rsp_pc;
    if (flush) begin
      ifid_bubble = 1'b1;
      issue       = 1'b1;
      state_nxt   = ST_PENDING;
    end else if (stall) begin
      if (state == ST_PENDING) begin
        buf_load  = 1'b1;
        state_nxt = ST_BUFFERED;
      end
    end else begin
      issue     = 1'b1;
      state_nxt = ST_PENDING;
      case (state)
        ST_BUFFERED: begin
          ifid_load    = 1'b1;
          ifid_inst_in = buf_inst;
          ifid_pc_in   = buf_pc;
        end
        ST_PENDING: ifid_load   = 1'b1;
        default:    ifid_bubble = 1'b1;
      endcase
    end
  end

  // Fetch PC and the PC tag of the response that will arrive next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_f   <= RESET_PC;
      rsp_pc <= RESET_PC;
    end else if (issue) begin
      rsp_pc <= imem_addr;
      pc_f   <= imem_addr + FOUR;
    end
  end

  // Park the response that arrives while Decode is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_inst <= NOP;
      buf_pc   <= '0;
    end else if (buf_load) begin
      buf_inst <= imem_rdata;
      buf_pc   <= rsp_pc;
    end
  end

  if_id_reg #(
    .WIDTH (WIDTH),
    .NOP   (NOP)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load),
    .bubble   (ifid_bubble),
    .inst_in  (ifid_inst_in),
    .pc_in    (ifid_pc_in),
    .inst     (inst),
    .pc       (pc_id),
    .pc_plus4 (pc_plus4_id),
    .valid    (valid_id)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random stall/flush
// traffic, compared against a stream-level model of the fetch sequence.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic [31:0] pc_id;
  logic [31:0] pc_plus4_id;
  logic        valid_id;

  int compared   = 0;
  int mismatched = 0;
  int stepno     = 0;

  // Stream model: after a restart at m_base, the n-th advancing edge
  // (counting the flush edge itself as the first) shows base+4*(n-2).
  logic [31:0] m_base;
  int unsigned m_n;

  fetch_stage #(
    .WIDTH    (32),
    .RESET_PC (RESET_PC),
    .NOP      (NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_en       (imem_en),
    .imem_rdata    (imem_rdata),
    .inst          (inst),
    .pc_id         (pc_id),
    .pc_plus4_id   (pc_plus4_id),
    .valid_id      (valid_id)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  // Synchronous instruction memory with one-cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s step %0d: observed %h expected %h", tag, stepno, obs, exp);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_inst",   inst,               NOP);
    check("rst_pc_id",  pc_id,              32'h0);
    check("rst_plus4",  pc_plus4_id,        32'h4);
    check("rst_valid",  {31'b0, valid_id},  32'h0);
    check("rst_en",     {31'b0, imem_en},   32'h0);
    check("rst_addr",   imem_addr,          RESET_PC);
  endtask

  task automatic check_ifid();
    logic        ev;
    logic [31:0] epc;
    ev  = (m_n >= 2);
    epc = ev ? (m_base + 32'(4 * (m_n - 2))) : 32'h0;
    check("valid_id",    {31'b0, valid_id}, {31'b0, ev});
    check("pc_id",       pc_id,             epc);
    check("inst",        inst,              ev ? mem_word(epc) : NOP);
    check("pc_plus4_id", pc_plus4_id,       epc + 32'h4);
  endtask

  // One clock cycle: drive at the falling edge, check fetch outputs,
  // advance the model at the rising edge, then check IF/ID.
  task automatic step(input logic s, input logic f, input logic [31:0] t);
    stepno++;
    stall         = s;
    flush         = f;
    branch_target = t;
    #1;
    check("imem_en",   {31'b0, imem_en}, {31'b0, (f | ~s)});
    check("imem_addr", imem_addr, f ? {t[31:2], 2'b00} : (m_base + 32'(4 * m_n)));
    @(posedge clk);
    if (f) begin
      m_base = {t[31:2], 2'b00};
      m_n    = 1;
    end else if (!s) begin
      m_n++;
    end
    #1;
    check_ifid();
    @(negedge clk);
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic pulse_reset();
    stepno++;
    rst   = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    #2;
    check_reset_vals();
    m_base = RESET_PC;
    m_n    = 0;
    @(posedge clk);
    #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst           = 1'b0;
    stall         = 1'b0;
    flush         = 1'b0;
    branch_target = '0;
    m_base        = RESET_PC;
    m_n           = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b1;

    // Straight-line fetch: valid at cycle 2, one instruction per cycle.
    repeat (5) step(1'b0, 1'b0, 32'h0);

    // Four-cycle stall while a response is pending, then release.
    repeat (4) step(1'b1, 1'b0, 32'h0);
    repeat (3) step(1'b0, 1'b0, 32'h0);

    // Redirect with low target bits set.
    step(1'b0, 1'b1, 32'h0000_0102);
    repeat (3) step(1'b0, 1'b0, 32'h0);

    // Flush together with stall while the buffer holds a response.
    repeat (2) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0200);
    repeat (2) step(1'b1, 1'b0, 32'h0);
    repeat (3) step(1'b0, 1'b0, 32'h0);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    repeat (4) step(1'b0, 1'b0, 32'h0);

    // Reset while a response is in flight, then restart.
    step(1'b0, 1'b0, 32'h0);
    pulse_reset();
    repeat (4) step(1'b0, 1'b0, 32'h0);

    // Random stall/flush traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 59) == 0) pulse_reset();
      else step(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
